// File: rtl/cv_countbit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cv_countbit_seq_if
//  Description : Producer/consumer valid-ready bundle for cv_countbit_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cv_countbit_seq_if #(
    parameter int ISIZE = 64,
    parameter int OSIZE = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [ISIZE-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OSIZE-1:0] out_count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count
    );
endinterface
`default_nettype wire

// File: rtl/cv_countbit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cv_countbit_seq
//  Description : Multi-cycle count of CBIT-valued bits, one CSIZE chunk per
//                cycle. Define CV_COUNTBIT_SEQ_EARLY_EXIT_EN to stop as soon
//                as no counted bits remain in the shifted word.
//  Revision    : 1.0 - initial release
// ============================================================================
module cv_countbit_seq #(
    parameter int ISIZE = 64,
    parameter int CSIZE = 8,
    parameter int OSIZE = 7,
    parameter int CBIT  = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cv_countbit_seq_if.slave bus,
    output logic             busy
);

    localparam int c_nchunk = ISIZE / CSIZE;
    localparam int c_idxw   = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_idxw-1:0] c_last_idx = c_idxw'(c_nchunk - 1);
    localparam logic c_cbit = (CBIT != 0);
    // Vacated top bits carry ~CBIT so they never contribute to the count.
    localparam logic [ISIZE-1:0] c_fill_mask =
        {ISIZE{~c_cbit}} & ~({ISIZE{1'b1}} >> CSIZE);

    typedef enum logic [1:0] {
        c_idle = 2'd0,
        c_run  = 2'd1,
        c_done = 2'd2
    } state_t;

    state_t           r_state;
    logic [ISIZE-1:0] r_sh;
    logic [OSIZE-1:0] r_acc;
    logic [c_idxw-1:0] r_idx;
    logic             r_out_valid;
    logic [OSIZE-1:0] r_out_count;

    logic [OSIZE-1:0] w_chunk_cnt;
    logic [OSIZE-1:0] w_sum;
    logic [ISIZE-1:0] w_sh_next;
    logic             w_exit;

    always_comb begin
        w_chunk_cnt = '0;
        for (int i = 0; i < CSIZE; i++) begin
            if (r_sh[i] == c_cbit) begin
                w_chunk_cnt = w_chunk_cnt + OSIZE'(1);
            end
        end
    end

    assign w_sum     = r_acc + w_chunk_cnt;
    assign w_sh_next = (r_sh >> CSIZE) | c_fill_mask;

`ifdef CV_COUNTBIT_SEQ_EARLY_EXIT_EN
    localparam logic [ISIZE-1:0] c_empty = {ISIZE{~c_cbit}};
    assign w_exit = (w_sh_next == c_empty);
`else
    assign w_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_sh        <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        r_sh    <= bus.in_data;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    r_acc <= w_sum;
                    r_sh  <= w_sh_next;
                    r_idx <= r_idx + c_idxw'(1);
                    if ((r_idx == c_last_idx) || w_exit) begin
                        r_out_count <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= c_done;
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Reset is the only input allowed to reach an output combinationally.
    assign bus.in_ready  = (r_state == c_idle) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_count = r_out_count;
    assign busy          = (r_state != c_idle);

endmodule
`default_nettype wire
